// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD tick counter and its segment decoder.
package bcd_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    typedef enum logic {
        WAIT_LOW,
        WAIT_HIGH
    } edge_state_t;

endpackage

// File: rtl/bcd_tick_counter_if.sv
// Signal bundle between the BCD tick counter and whoever drives/observes it.
interface bcd_tick_counter_if;
    import bcd_pkg::*;

    logic tick_in;
    logic en;
    logic clr;
    logic up_dn;
    bcd_t digit_lo;
    bcd_t digit_hi;
    logic carry_out;
    seg_t seg_lo;
    seg_t seg_hi;

    modport master (
        output tick_in, en, clr, up_dn,
        input  digit_lo, digit_hi, carry_out, seg_lo, seg_hi
    );

    modport slave (
        input  tick_in, en, clr, up_dn,
        output digit_lo, digit_hi, carry_out, seg_lo, seg_hi
    );

endinterface

// File: rtl/seg7_dec.sv
// BCD to seven-segment decoder, active-low, bit6..0 = g..a; codes 10..15 blank.
module seg7_dec
    import bcd_pkg::*;
(
    input  bcd_t bcd,
    output seg_t seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// Two-digit BCD up/down counter stepped by rising edges of a slow divided clock.
// Optional seven-segment decode is enabled by defining BCD_SEG_DECODE_EN.
module bcd_tick_counter
    import bcd_pkg::*;
#(
    parameter int unsigned MOD_HI = 5,
    parameter int unsigned MOD_LO = 9
) (
    input  logic               clk_in,
    input  logic               reset,
    bcd_tick_counter_if.slave  bus
);

    if (MOD_HI > 9 || MOD_LO > 9) begin : g_mod_check
        $error("bcd_tick_counter: MOD_HI and MOD_LO must each be in 0..9");
    end

    localparam bcd_t TERM_HI = MOD_HI[3:0];
    localparam bcd_t TERM_LO = MOD_LO[3:0];

    logic        sync_p0, sync_p1;
    logic        vld_p0, vld_p1;
    edge_state_t state, state_nxt;
    logic        step;
    bcd_t        cnt_lo_p2, cnt_hi_p2;
    logic        carry_p2;
    seg_t        seg_lo_w, seg_hi_w;

    // Stage 0/1: two-flop synchronizer; vld marks when sync_p1 holds a real sample
    // rather than the reset value, so a tick held high through reset is not
    // mistaken for a low level.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            sync_p0 <= bus.tick_in;
            sync_p1 <= sync_p0;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) state <= WAIT_LOW;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        case (state)
            WAIT_LOW:  if (vld_p1 && !sync_p1) state_nxt = WAIT_HIGH;
            WAIT_HIGH: if (sync_p1) begin
                step      = 1'b1;
                state_nxt = WAIT_LOW;
            end
            default:   state_nxt = WAIT_LOW;
        endcase
    end

    // Stage 2: counter digits and wrap pulse
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_lo_p2 <= '0;
            cnt_hi_p2 <= '0;
            carry_p2  <= 1'b0;
        end else begin
            carry_p2 <= 1'b0;
            if (bus.clr) begin
                cnt_lo_p2 <= '0;
                cnt_hi_p2 <= '0;
            end else if (step && bus.en) begin
                if (bus.up_dn) begin
                    if (cnt_hi_p2 == TERM_HI && cnt_lo_p2 == TERM_LO) begin
                        cnt_lo_p2 <= '0;
                        cnt_hi_p2 <= '0;
                        carry_p2  <= 1'b1;
                    end else if (cnt_lo_p2 == 4'd9) begin
                        cnt_lo_p2 <= '0;
                        cnt_hi_p2 <= cnt_hi_p2 + 4'd1;
                    end else begin
                        cnt_lo_p2 <= cnt_lo_p2 + 4'd1;
                    end
                end else begin
                    if (cnt_hi_p2 == 4'd0 && cnt_lo_p2 == 4'd0) begin
                        cnt_lo_p2 <= TERM_LO;
                        cnt_hi_p2 <= TERM_HI;
                        carry_p2  <= 1'b1;
                    end else if (cnt_lo_p2 == 4'd0) begin
                        cnt_lo_p2 <= 4'd9;
                        cnt_hi_p2 <= cnt_hi_p2 - 4'd1;
                    end else begin
                        cnt_lo_p2 <= cnt_lo_p2 - 4'd1;
                    end
                end
            end
        end
    end

`ifdef BCD_SEG_DECODE_EN
    seg7_dec u_seg_lo (.bcd(cnt_lo_p2), .seg(seg_lo_w));
    seg7_dec u_seg_hi (.bcd(cnt_hi_p2), .seg(seg_hi_w));
`else
    assign seg_lo_w = SEG_BLANK;
    assign seg_hi_w = SEG_BLANK;
`endif

    assign bus.digit_lo  = cnt_lo_p2;
    assign bus.digit_hi  = cnt_hi_p2;
    assign bus.carry_out = carry_p2;
    assign bus.seg_lo    = seg_lo_w;
    assign bus.seg_hi    = seg_hi_w;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Bench for bcd_tick_counter: a default 00..59 instance and a 00..23 instance run in lockstep.
module tb_bcd_tick_counter;
    import bcd_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic tick, en, clr, up_dn;

    always #5 clk = ~clk;

    bcd_tick_counter_if ifa ();
    bcd_tick_counter_if ifb ();

    assign ifa.tick_in = tick;
    assign ifa.en      = en;
    assign ifa.clr     = clr;
    assign ifa.up_dn   = up_dn;
    assign ifb.tick_in = tick;
    assign ifb.en      = en;
    assign ifb.clr     = clr;
    assign ifb.up_dn   = up_dn;

    bcd_tick_counter dut_a (.clk_in(clk), .reset(rst), .bus(ifa));
    bcd_tick_counter #(.MOD_HI(2), .MOD_LO(3)) dut_b (.clk_in(clk), .reset(rst), .bus(ifb));

    typedef struct {
        int   a;
        logic ca;
        int   b;
        logic cb;
    } exp_t;

    typedef struct {
        bit up;
        bit en;
        bit clr;
        int n;
        int exp_a;
        int exp_b;
        bit exp_ca;
        bit exp_cb;
    } vec_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   ma    = 0;
    int   mb    = 0;
    logic last_ca, last_cb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic seg_t seg_model(input int d);
`ifdef BCD_SEG_DECODE_EN
        seg_t tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tbl[d];
`else
        return (d >= 0) ? SEG_BLANK : 7'h00;
`endif
    endfunction

    task automatic model_step(input bit up, input bit e, input bit c);
        exp_t x;
        x.ca = 1'b0;
        x.cb = 1'b0;
        if (c) begin
            ma = 0;
            mb = 0;
        end else if (e) begin
            if (up) begin
                x.ca = (ma == 59);
                x.cb = (mb == 23);
                ma = (ma + 1) % 60;
                mb = (mb + 1) % 24;
            end else begin
                x.ca = (ma == 0);
                x.cb = (mb == 0);
                ma = (ma + 59) % 60;
                mb = (mb + 23) % 24;
            end
        end
        x.a = ma;
        x.b = mb;
        sbq.push_back(x);
    endtask

    task automatic check_state(input string nm, input int a, input int b);
        chk({nm, "_a_digits"}, {24'd0, ifa.digit_hi, ifa.digit_lo}, {24'd0, bcd(a)});
        chk({nm, "_b_digits"}, {24'd0, ifb.digit_hi, ifb.digit_lo}, {24'd0, bcd(b)});
        chk({nm, "_a_seg_lo"}, {25'd0, ifa.seg_lo}, {25'd0, seg_model(a % 10)});
        chk({nm, "_a_seg_hi"}, {25'd0, ifa.seg_hi}, {25'd0, seg_model(a / 10)});
    endtask

    // Starts at #1 after an edge with tick low long enough; rise -> update on 3rd edge.
    task automatic do_tick(input bit up, input bit e, input bit c, input bit lat);
        exp_t x;
        int   olda, oldb;
        olda  = ma;
        oldb  = mb;
        up_dn = up;
        en    = e;
        tick  = 1'b1;
        model_step(up, e, c);
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (lat) check_state("early", olda, oldb);
        clr = c;
        @(posedge clk); #1;
        clr = 1'b0;
        x = sbq.pop_front();
        check_state("step", x.a, x.b);
        chk("carry_a", {31'd0, ifa.carry_out}, {31'd0, x.ca});
        chk("carry_b", {31'd0, ifb.carry_out}, {31'd0, x.cb});
        last_ca = ifa.carry_out;
        last_cb = ifb.carry_out;
        @(posedge clk); #1;
        chk("carry_a_width", {31'd0, ifa.carry_out}, 32'd0);
        chk("carry_b_width", {31'd0, ifb.carry_out}, 32'd0);
        tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    vec_t vecs [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1, 1, 0, 58, 59, 11, 0, 0};
        vecs[1]  = '{1, 1, 0,  1,  0, 12, 1, 0};
        vecs[2]  = '{0, 1, 0,  1, 59, 11, 1, 0};
        vecs[3]  = '{1, 1, 1,  1,  0,  0, 0, 0};
        vecs[4]  = '{0, 1, 0,  1, 59, 23, 1, 1};
        vecs[5]  = '{1, 1, 0,  1,  0,  0, 1, 1};
        vecs[6]  = '{1, 1, 0,  9,  9,  9, 0, 0};
        vecs[7]  = '{1, 1, 0,  1, 10, 10, 0, 0};
        vecs[8]  = '{1, 1, 0, 13, 23, 23, 0, 0};
        vecs[9]  = '{1, 1, 0,  1, 24,  0, 0, 1};
        vecs[10] = '{1, 0, 0,  5, 24,  0, 0, 0};
        vecs[11] = '{1, 1, 0, 26, 50,  2, 0, 0};
        vecs[12] = '{0, 1, 0,  1, 49,  1, 0, 0};
        vecs[13] = '{0, 1, 0, 12, 37, 13, 0, 0};

        // Reset with tick held high: no step after release until tick is seen low.
        rst = 1'b1; tick = 1'b1; en = 1'b1; clr = 1'b0; up_dn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_carry_a", {31'd0, ifa.carry_out}, 32'd0);
        check_state("reset", 0, 0);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_state("tick_high_release", 0, 0);
        tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_tick(1'b1, 1'b1, 1'b0, 1'b1);
        check_state("first_tick", 1, 1);

        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < vecs[i].n; k++)
                do_tick(vecs[i].up, vecs[i].en, vecs[i].clr, 1'b0);
            chk($sformatf("vec%0d_a", i), {24'd0, ifa.digit_hi, ifa.digit_lo}, {24'd0, bcd(vecs[i].exp_a)});
            chk($sformatf("vec%0d_b", i), {24'd0, ifb.digit_hi, ifb.digit_lo}, {24'd0, bcd(vecs[i].exp_b)});
            chk($sformatf("vec%0d_ca", i), {31'd0, last_ca}, {31'd0, vecs[i].exp_ca});
            chk($sformatf("vec%0d_cb", i), {31'd0, last_cb}, {31'd0, vecs[i].exp_cb});
        end

        // Reset mid-count at 37 while the edge FSM is armed and tick is high.
        tick = 1'b1;
        rst  = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ma  = 0;
        mb  = 0;
        check_state("midreset", 0, 0);
        chk("midreset_carry_a", {31'd0, ifa.carry_out}, 32'd0);
        chk("midreset_carry_b", {31'd0, ifb.carry_out}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check_state("midreset_hold", 0, 0);
        tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_tick(1'b1, 1'b1, 1'b0, 1'b1);
        check_state("after_reset_tick", 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_tick_counter.md
Name: bcd_tick_counter

Overview:
- Downstream consumer of the divide-by-10 clock divider's clk_out.
- Detects rising edges of the divided clock in the fast clk_in domain.
- Runs a two-digit BCD up/down counter with a programmable modulus, defaulting to 00..59.
- Provides a wrap carry/borrow pulse and seven-segment drive for both digits.

Parameters:
- MOD_HI, default 5, terminal tens digit (0..9).
- MOD_LO, default 9, units digit at the terminal count (0..9). Terminal count = MOD_HI:MOD_LO.

Ports:
- clk_in  input  1  system clock.
- reset  input  1  synchronous reset, active-high.
- tick_in  input  1  divided clock from the divider; level, asynchronous to count logic.
- en  input  1  count enable; steps arriving while low are discarded.
- clr  input  1  synchronous clear to 00.
- up_dn  input  1  1 = count up, 0 = count down.
- digit_lo  output  4  units BCD digit.
- digit_hi  output  4  tens BCD digit.
- carry_out  output  1  one-cycle pulse on wrap, both directions.
- seg_lo  output  7  units segments, active-low, bit6..0 = g..a.
- seg_hi  output  7  tens segments, same format.

Behaviour:
- Interface: one clock, clk_in; reset is synchronous and active-high.
- Reset values: digit_lo = digit_hi = 0, carry_out = 0, sync flops = 0, edge FSM = WAIT_LOW. seg_* = 7'b1000000 (decoded "0").
- Input sync: tick_in passes through a two-flop synchronizer, giving tick_s.
- Edge FSM, two states:
  - WAIT_LOW: go to WAIT_HIGH when tick_s == 0.
  - WAIT_HIGH: when tick_s == 1, assert step for one cycle and go to WAIT_LOW.
  - A tick_in that is high at reset release produces no step until it has been seen low.
- Latency: the digits update on the 3rd clk_in rising edge after tick_in rises (setup met).
- Priority: reset > clr > (step & en).
- clr: digits go to 00 and carry_out = 0. The FSM is not affected.
- Count up (step & en & up_dn):
  - At MOD_HI:MOD_LO: go to 00 and set carry_out = 1.
  - Else if digit_lo == 9: digit_lo = 0, digit_hi + 1.
  - Else: digit_lo + 1.
- Count down (step & en & ~up_dn):
  - At 00: load MOD_HI:MOD_LO and set carry_out = 1.
  - Else if digit_lo == 0: digit_lo = 9, digit_hi - 1.
  - Else: digit_lo - 1.
- carry_out:
  - Registered; high in exactly the cycle the wrapped value first appears.
  - Low in all other cycles.
- en low: a pending step is dropped, not queued.
- up_dn is sampled only on step cycles.
- Segments: combinational decode of the registered digits. Codes 10..15 decode to 7'h7F (blank); they are unreachable in normal operation.
- Parameter check: an elaboration-time error if MOD_HI > 9 or MOD_LO > 9.

Optional Feature:
- Macro: BCD_SEG_DECODE_EN.
- Defined: the seg7_dec instances drive seg_lo and seg_hi as specified above.
- Undefined: no decoder is instantiated and seg_lo = seg_hi = 7'h7F constant. The port list is unchanged; all counting behaviour is identical.

Decomposition:
- Package bcd_pkg:
  - typedef bcd_t (logic [3:0]);
  - typedef seg_t (logic [6:0]);
  - constant SEG_BLANK = 7'h7F;
  - enum edge_state_t {WAIT_LOW, WAIT_HIGH}.
- Sub-module seg7_dec: bcd_t in, seg_t out, purely combinational. Instantiated twice.

Test Plan:
- Reset with tick_in held high, then release: digits stay 00 with no step. tick_in low then high: 01 appears on the 3rd clk_in edge after the rise.
- Up from 00, 59 ticks: reads 59, seg_hi = 7'b0010010. 60th tick: 00, carry_out high exactly 1 cycle, seg_lo = 7'b1000000.
- up_dn = 0 from 00, one tick: 59 with a carry_out pulse. From 50, one tick: 49 with no pulse.
- Instance MOD_HI = 2, MOD_LO = 3: 09 -> 10 with no carry; 23 -> 00 with carry. Down from 00 -> 23.
- en = 0 across 5 ticks: value unchanged. clr in the same cycle as a step: 00, carry_out stays 0.
- reset asserted mid-count at 37: 00 on the next clk_in edge, carry_out 0, FSM in WAIT_LOW.
